// File: rtl/txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : txn_sequencer
// Description : Request/response sequencer in front of the ATM datapath, with
//               per-account PIN-failure lockout and a completion timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module txn_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_PIN_FAILS  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [3:0]  req_acc,
    input  logic [3:0]  req_pin,
    input  logic [3:0]  req_dest,
    input  logic [31:0] req_amount,
    output logic        dp_start,
    output logic [1:0]  dp_op,
    output logic [3:0]  dp_acc,
    output logic [3:0]  dp_pin,
    output logic [3:0]  dp_dest,
    output logic [31:0] dp_amount,
    input  logic        dp_done,
    input  logic [3:0]  dp_status,
    output logic        rsp_valid,
    output logic [3:0]  rsp_status,
    output logic [15:0] lock_mask
);

    localparam int              c_CW          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_TMO_LAST    = c_CW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CW-1:0] c_TMO_ONE     = c_CW'(1);
    localparam logic [1:0]      c_FAIL_LOCK   = 2'(MAX_PIN_FAILS);
    localparam logic [3:0]      c_ST_OK       = 4'h0;
    localparam logic [3:0]      c_ST_BAD_PIN  = 4'h1;
    localparam logic [3:0]      c_ST_SAME_ACC = 4'hB;
    localparam logic [3:0]      c_ST_ZERO_AMT = 4'hC;
    localparam logic [3:0]      c_ST_LOCKED   = 4'hD;
    localparam logic [3:0]      c_ST_TIMEOUT  = 4'hE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [c_CW-1:0] r_tmo_cnt;
    logic [c_CW-1:0] w_tmo_inc;
    logic [1:0]      r_fail_cnt [16];
    logic [1:0]      w_fail_inc;
    logic            w_hs;
    logic            w_reject;
    logic [3:0]      w_rej_status;
    logic            w_done;
    logic            w_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        req_ready    = 1'b0;
        dp_start     = 1'b0;
        rsp_valid    = 1'b0;
        w_hs         = 1'b0;
        w_reject     = 1'b0;
        w_rej_status = c_ST_OK;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
        w_tmo_inc    = r_tmo_cnt + c_TMO_ONE;
        w_fail_inc   = (r_fail_cnt[dp_acc] == 2'b11) ? 2'b11 : r_fail_cnt[dp_acc] + 2'd1;

        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_hs = 1'b1;
                    // Reject priority: locked account, then zero amount, then self-transfer.
                    if (lock_mask[req_acc]) begin
                        w_reject     = 1'b1;
                        w_rej_status = c_ST_LOCKED;
                    end else if ((req_op != 2'd0) && (req_amount == 32'd0)) begin
                        w_reject     = 1'b1;
                        w_rej_status = c_ST_ZERO_AMT;
                    end else if ((req_op == 2'd3) && (req_dest == req_acc)) begin
                        w_reject     = 1'b1;
                        w_rej_status = c_ST_SAME_ACC;
                    end
                    w_next = w_reject ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                dp_start = 1'b1;
                w_next   = WAIT;
            end
            WAIT: begin
                // Completion takes precedence over an expiring timeout.
                if (dp_done) begin
                    w_done = 1'b1;
                    w_next = RESP;
                end else if (w_tmo_inc == c_TMO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                w_next    = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_op      <= 2'd0;
            dp_acc     <= 4'd0;
            dp_pin     <= 4'd0;
            dp_dest    <= 4'd0;
            dp_amount  <= 32'd0;
            rsp_status <= 4'd0;
            lock_mask  <= 16'd0;
            r_tmo_cnt  <= '0;
            for (int i = 0; i < 16; i++) begin
                r_fail_cnt[i] <= 2'd0;
            end
        end else begin
            if (w_hs) begin
                dp_op     <= req_op;
                dp_acc    <= req_acc;
                dp_pin    <= req_pin;
                dp_dest   <= req_dest;
                dp_amount <= req_amount;
            end

            if (w_reject) begin
                rsp_status <= w_rej_status;
            end

            if (r_state == ISSUE) begin
                r_tmo_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_tmo_cnt <= w_tmo_inc;
            end

            if (w_done) begin
                rsp_status <= dp_status;
                if (dp_status == c_ST_BAD_PIN) begin
                    r_fail_cnt[dp_acc] <= w_fail_inc;
                    if (w_fail_inc >= c_FAIL_LOCK) begin
                        lock_mask[dp_acc] <= 1'b1;
                    end
                end else if (dp_status == c_ST_OK) begin
                    r_fail_cnt[dp_acc] <= 2'd0;
                end
            end else if (w_timeout) begin
                rsp_status <= c_ST_TIMEOUT;
            end
        end
    end

endmodule
`default_nettype wire
